// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/gnt arbiter and one-cycle access sequencer in
// front of the single-port DataMemory.
// Requester 0 is the pipeline MEM stage. Requester 1 is the debug/loader port.
// Optional feature macro DMEM_ARB_RR_EN selects the tie-break policy.
//   Defined:   round-robin tie-break, using a one-bit last-served pointer.
//   Undefined: fixed priority, where port 0 wins every tie.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int WORD_LEN = 32,
    localparam int AW      = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                we0,
    input  logic [AW-1:0]       addr0,
    input  logic [WORD_LEN-1:0] wdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [AW-1:0]       addr1,
    input  logic [WORD_LEN-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [WORD_LEN-1:0] rdata0,
    output logic [WORD_LEN-1:0] rdata1,
    output logic                mem_write,
    output logic [AW-1:0]       mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                busy
);

    localparam logic StIdle   = 1'b0;
    localparam logic StAccess = 1'b1;

    logic                state_q, state_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [WORD_LEN-1:0] rdata0_q, rdata0_d;
    logic [WORD_LEN-1:0] rdata1_q, rdata1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic                pick1;
`ifdef DMEM_ARB_RR_EN
    logic                last_q, last_d;
`endif

    // Choose the winner when the block is idle.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        // On a tie, the port that was not served last wins.
        pick1 = req1 & (~req0 | ~last_q);
`else
        pick1 = req1 & ~req0;
`endif
    end

    // Next-state logic. Capture the request in IDLE; complete the access in ACCESS.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_d    = last_q;
`endif
        if (state_q == StIdle) begin
            if (req0 | req1) begin
                state_d = StAccess;
                sel_d   = pick1;
                we_d    = pick1 ? we1 : we0;
                addr_d  = pick1 ? addr1 : addr0;
                wdata_d = pick1 ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
                last_d  = pick1;
`endif
            end
        end else begin
            // On a write, mem_rdata still holds the pre-write content at this edge.
            state_d = StIdle;
            if (sel_q) begin
                rdata1_d  = mem_rdata;
                rvalid1_d = 1'b1;
            end else begin
                rdata0_d  = mem_rdata;
                rvalid0_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // Outputs are decoded from registered state only.
    // A reset during ACCESS drops mem_write at once, so the write is not committed.
    always_comb begin
        busy      = (state_q == StAccess);
        gnt0      = busy & ~sel_q;
        gnt1      = busy & sel_q;
        mem_write = busy & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rvalid0   = rvalid0_q;
        rvalid1   = rvalid1_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

endmodule
